// File: rtl/edulent_pkg.sv
// Shared definitions for the edulent 8-bit CPU: transfer commands, opcodes,
// SP strobe codes, controller states and instruction classes.
package edulent_pkg;

    // Register-transfer commands driven into data_path
    localparam logic [3:0] XFER_NONE        = 4'h0;
    localparam logic [3:0] XFER_MA_PC       = 4'h1;
    localparam logic [3:0] XFER_MD_MEM      = 4'h2;
    localparam logic [3:0] XFER_IR_MD       = 4'h3;
    localparam logic [3:0] XFER_MA_MD       = 4'h4;
    localparam logic [3:0] XFER_REG_MD      = 4'h5;
    localparam logic [3:0] XFER_MA_SP       = 4'h7;
    localparam logic [3:0] XFER_MD_REG      = 4'h8;
    localparam logic [3:0] XFER_MEM_MD      = 4'h9;
    localparam logic [3:0] XFER_REG_R       = 4'hA;
    localparam logic [3:0] XFER_PC_MD_COND  = 4'hB;
    localparam logic [3:0] XFER_IN          = 4'hC;
    localparam logic [3:0] XFER_OUT         = 4'hD;
    localparam logic [3:0] XFER_PC_MD       = 4'hE;
    localparam logic [3:0] XFER_MD_PC       = 4'hF;

    // Opcodes with dedicated sequences
    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_LDA_IMM  = 8'h11;
    localparam logic [7:0] OP_LDAP_IMM = 8'h13;
    localparam logic [7:0] OP_POPA     = 8'h14;
    localparam logic [7:0] OP_LDA_DIR  = 8'h19;
    localparam logic [7:0] OP_LDAP_DIR = 8'h1B;
    localparam logic [7:0] OP_POPAP    = 8'h1E;
    localparam logic [7:0] OP_STA      = 8'h21;
    localparam logic [7:0] OP_STAP     = 8'h23;
    localparam logic [7:0] OP_PUSHA    = 8'h2C;
    localparam logic [7:0] OP_PUSHAP   = 8'h2E;
    localparam logic [7:0] OP_NOT      = 8'h50;
    localparam logic [7:0] OP_SHR      = 8'h90;
    localparam logic [7:0] OP_JMP      = 8'hA1;
    localparam logic [7:0] OP_JZ       = 8'hA5;
    localparam logic [7:0] OP_JC       = 8'hA9;
    localparam logic [7:0] OP_CALL     = 8'hB0;
    localparam logic [7:0] OP_RET      = 8'hC1;
    localparam logic [7:0] OP_IN       = 8'hD0;
    localparam logic [7:0] OP_OUT      = 8'hE0;
    localparam logic [7:0] OP_HLT      = 8'hFF;

    // Stack pointer strobe codes
    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC  = 2'b10;

    typedef enum logic [2:0] {
        RST, FETCH0, FETCH1, FETCH2, DECODE, EXEC, HALT
    } cu_state_t;

    typedef enum logic [3:0] {
        CLS_LD, CLS_POP, CLS_ST, CLS_PUSH, CLS_ALU2, CLS_ALU1, CLS_JMP,
        CLS_CALL, CLS_RET, CLS_IN, CLS_OUT, CLS_NOP, CLS_HLT
    } instr_class_t;

    // Index of the final EXEC step for a class (sequence length minus one)
    function automatic logic [2:0] seq_last(input instr_class_t cls, input logic direct);
        case (cls)
            CLS_LD:   return direct ? 3'd4 : 3'd2;
            CLS_POP:  return 3'd3;
            CLS_ST:   return 3'd4;
            CLS_PUSH: return 3'd2;
            CLS_ALU2: return direct ? 3'd5 : 3'd3;
            CLS_ALU1: return 3'd1;
            CLS_JMP:  return 3'd2;
            CLS_CALL: return 3'd5;
            CLS_RET:  return 3'd5;
            default:  return 3'd0;
        endcase
    endfunction

    // Shared operand fetch: MA=PC (with PC+1), MD=mem, then for direct MA=MD, MD=mem
    function automatic logic [3:0] operand_cmd(input logic [2:0] step);
        case (step)
            3'd0:    return XFER_MA_PC;
            3'd1:    return XFER_MD_MEM;
            3'd2:    return XFER_MA_MD;
            3'd3:    return XFER_MD_MEM;
            default: return XFER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between control_unit (master) and data_path (slave).
interface control_unit_if;
    logic [7:0] i_ir;
    logic [3:0] o_transfer_cmd;
    logic       o_inc_pc;
    logic [1:0] o_inc_dec_sp;
    logic       o_alu_calculate;
    logic       o_alu_res_to_ap;
    logic       o_reset_ir;
    logic       o_halted;

    modport master (
        input  i_ir,
        output o_transfer_cmd, o_inc_pc, o_inc_dec_sp, o_alu_calculate,
               o_alu_res_to_ap, o_reset_ir, o_halted
    );

    modport slave (
        output i_ir,
        input  o_transfer_cmd, o_inc_pc, o_inc_dec_sp, o_alu_calculate,
               o_alu_res_to_ap, o_reset_ir, o_halted
    );
endinterface

// File: rtl/control_unit_decoder.sv
// Opcode classifier: sequence class, direct addressing and AP selection.
import edulent_pkg::*;

module instr_decoder (
    input  logic [7:0]   opcode,
    output instr_class_t instr_class,
    output logic         direct,
    output logic         to_ap
);

    // Exact opcodes first; binary ALU ops are recognised by their high nibble
    always_comb begin
        instr_class = CLS_NOP;
        direct      = 1'b0;
        to_ap       = 1'b0;
        case (opcode)
            OP_LDA_IMM, OP_LDAP_IMM: begin instr_class = CLS_LD; to_ap = opcode[1]; end
            OP_LDA_DIR, OP_LDAP_DIR: begin instr_class = CLS_LD; direct = 1'b1; to_ap = opcode[1]; end
            OP_POPA, OP_POPAP:       begin instr_class = CLS_POP; to_ap = opcode[1]; end
            OP_STA, OP_STAP:         begin instr_class = CLS_ST; to_ap = opcode[1]; end
            OP_PUSHA, OP_PUSHAP:     begin instr_class = CLS_PUSH; to_ap = opcode[1]; end
            OP_NOT, OP_SHR:          instr_class = CLS_ALU1;
            OP_JMP, OP_JZ, OP_JC:    instr_class = CLS_JMP;
            OP_CALL:                 instr_class = CLS_CALL;
            OP_RET:                  instr_class = CLS_RET;
            OP_IN:                   instr_class = CLS_IN;
            OP_OUT:                  instr_class = CLS_OUT;
            OP_HLT:                  instr_class = CLS_HLT;
            default: begin
                case (opcode[7:4])
                    4'h3, 4'h4: begin
                        instr_class = CLS_ALU2;
                        direct      = opcode[3];
                        to_ap       = opcode[1];
                    end
                    4'h6, 4'h7, 4'h8: begin
                        instr_class = CLS_ALU2;
                        direct      = opcode[3];
                    end
                    default: instr_class = CLS_NOP;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Microprogrammed sequencer for the edulent CPU: fetch, decode, execute,
// one data_path micro-step per clock. Outputs depend only on registered state.
import edulent_pkg::*;

module control_unit (
    input  logic            i_clk,
    input  logic            i_rstn,
    control_unit_if.master  cu
);

    cu_state_t    state_q, state_d;
    logic [2:0]   step_q, step_d;
    logic [7:0]   opcode_q;
    instr_class_t instr_class;
    logic         direct;
    logic         to_ap;
    logic [2:0]   last_step;
    logic         is_last;

    logic [3:0]   cmd;
    logic         inc_pc;
    logic [1:0]   sp_ctl;
    logic         calc;
    logic         res_to_ap;
    logic         reset_ir;
    logic         halted;

    instr_decoder u_decoder (
        .opcode      (opcode_q),
        .instr_class (instr_class),
        .direct      (direct),
        .to_ap       (to_ap)
    );

    assign last_step = seq_last(instr_class, direct);
    assign is_last   = (step_q == last_step);

    // State and EXEC step counter; async reset drops straight back to RST
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= RST;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Opcode is captured once in DECODE so IR clears mid-sequence are harmless
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            opcode_q <= 8'h00;
        end else if (state_q == DECODE) begin
            opcode_q <= cu.i_ir;
        end
    end

    // Next state and Moore outputs from state, step counter and latched opcode
    always_comb begin
        state_d   = state_q;
        step_d    = 3'd0;
        cmd       = XFER_NONE;
        inc_pc    = 1'b0;
        sp_ctl    = SP_HOLD;
        calc      = 1'b0;
        res_to_ap = 1'b0;
        reset_ir  = 1'b0;
        halted    = 1'b0;
        case (state_q)
            RST:    state_d = FETCH0;
            FETCH0: begin cmd = XFER_MA_PC; inc_pc = 1'b1; state_d = FETCH1; end
            FETCH1: begin cmd = XFER_MD_MEM; state_d = FETCH2; end
            FETCH2: begin cmd = XFER_IR_MD; state_d = DECODE; end
            DECODE: state_d = (cu.i_ir == OP_HLT) ? HALT : EXEC;
            EXEC: begin
                step_d = step_q + 3'd1;
                if (is_last) begin
                    reset_ir = 1'b1;
                    state_d  = FETCH0;
                    step_d   = 3'd0;
                end
                case (instr_class)
                    CLS_LD: begin
                        if (is_last) begin
                            cmd = XFER_REG_MD;
                        end else begin
                            cmd    = operand_cmd(step_q);
                            inc_pc = (step_q == 3'd0);
                        end
                    end
                    CLS_ALU2: begin
                        if (is_last) begin
                            cmd       = XFER_REG_R;
                            res_to_ap = to_ap;
                        end else if (step_q == last_step - 3'd1) begin
                            calc      = 1'b1;
                            res_to_ap = to_ap;
                        end else begin
                            cmd    = operand_cmd(step_q);
                            inc_pc = (step_q == 3'd0);
                        end
                    end
                    CLS_ALU1: begin
                        if (is_last) cmd = XFER_REG_R;
                        else         calc = 1'b1;
                    end
                    CLS_POP: begin
                        case (step_q)
                            3'd0:    sp_ctl = SP_INC;
                            3'd1:    cmd = XFER_MA_SP;
                            3'd2:    cmd = XFER_MD_MEM;
                            3'd3:    cmd = XFER_REG_MD;
                            default: ;
                        endcase
                    end
                    CLS_ST: begin
                        case (step_q)
                            3'd0:    begin cmd = XFER_MA_PC; inc_pc = 1'b1; end
                            3'd1:    cmd = XFER_MD_MEM;
                            3'd2:    cmd = XFER_MA_MD;
                            3'd3:    cmd = XFER_MD_REG;
                            3'd4:    cmd = XFER_MEM_MD;
                            default: ;
                        endcase
                    end
                    CLS_PUSH: begin
                        case (step_q)
                            3'd0:    cmd = XFER_MA_SP;
                            3'd1:    cmd = XFER_MD_REG;
                            3'd2:    begin cmd = XFER_MEM_MD; sp_ctl = SP_DEC; end
                            default: ;
                        endcase
                    end
                    CLS_JMP: begin
                        case (step_q)
                            3'd0:    begin cmd = XFER_MA_PC; inc_pc = 1'b1; end
                            3'd1:    cmd = XFER_MD_MEM;
                            3'd2:    cmd = XFER_PC_MD_COND;
                            default: ;
                        endcase
                    end
                    CLS_CALL: begin
                        case (step_q)
                            3'd0:    cmd = XFER_MA_SP;
                            3'd1:    cmd = XFER_MD_PC;
                            3'd2:    begin cmd = XFER_MEM_MD; sp_ctl = SP_DEC; end
                            3'd3:    begin cmd = XFER_MA_PC; inc_pc = 1'b1; end
                            3'd4:    cmd = XFER_MD_MEM;
                            3'd5:    cmd = XFER_PC_MD_COND;
                            default: ;
                        endcase
                    end
                    CLS_RET: begin
                        case (step_q)
                            3'd0:    sp_ctl = SP_INC;
                            3'd1:    cmd = XFER_MA_SP;
                            3'd2:    cmd = XFER_MD_MEM;
                            3'd3:    cmd = XFER_REG_MD;
                            3'd4:    cmd = XFER_PC_MD;
                            3'd5:    inc_pc = 1'b1;
                            default: ;
                        endcase
                    end
                    CLS_IN:  cmd = XFER_IN;
                    CLS_OUT: cmd = XFER_OUT;
                    default: ;
                endcase
            end
            HALT:    halted = 1'b1;
            default: state_d = RST;
        endcase
    end

    assign cu.o_transfer_cmd  = cmd;
    assign cu.o_inc_pc        = inc_pc;
    assign cu.o_inc_dec_sp    = sp_ctl;
    assign cu.o_alu_calculate = calc;
    assign cu.o_alu_res_to_ap = res_to_ap;
    assign cu.o_reset_ir      = reset_ir;
    assign cu.o_halted        = halted;

endmodule
